// File: rtl/dictionary_encoder_if.sv
// Streaming beat bundle: data plus keep/last qualifiers under a valid/ready handshake.
interface data_i #(
   parameter type T = logic [7:0]
);
   T     data;
   logic keep;
   logic last;
   logic valid;
   logic ready;

   modport m (output data, keep, last, valid, input ready);
   modport s (input data, keep, last, valid, output ready);
endinterface

// File: rtl/dictionary_encoder.sv
// Streaming dictionary encoder: maps each input value to a dense id via a
// register CAM and emits every newly seen value once, in id order. The table
// is rebuilt per batch; a batch ends on a retired beat with last=1.
module dictionary_encoder #(
   parameter type value_t  = logic [15:0],
   parameter type id_t     = logic [7:0],
   parameter int  CAPACITY = 64
) (
   input  logic clk,
   input  logic rst,
   data_i.s     in,
   data_i.m     out_ids,
   data_i.m     out_dict,
   output logic overflow
);
   localparam int CW  = $clog2(CAPACITY) + 1;
   localparam int IDW = $bits(id_t);
   localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);

   value_t              tbl_val [CAPACITY];
   logic [CAPACITY-1:0] tbl_vld;
   logic [CW-1:0]       count;

   value_t s1_val;
   logic   s1_keep, s1_last, s1_valid;
   logic   ids_done, dict_done;

   logic [CAPACITY-1:0] match;
   logic [CW-1:0]       hit_idx;
   logic [IDW-1:0]      id_w;
   logic hit, full, alloc, full_miss, dict_needed;
   logic ids_hs, dict_hs, ids_ok, dict_ok, retire;

   // CAM compare of the S1 value against every live entry
   always_comb begin
      match = '0;
      for (int i = 0; i < CAPACITY; i++)
         match[i] = tbl_vld[i] && (tbl_val[i] == s1_val);
   end

   // Lowest matching index wins
   always_comb begin
      hit_idx = '0;
      for (int i = CAPACITY - 1; i >= 0; i--)
         if (match[i]) hit_idx = CW'(i);
   end

   assign hit         = |match;
   assign full        = (count >= CAP_C);
   assign alloc       = s1_keep && !hit && !full;
   assign full_miss   = s1_keep && !hit && full;
   assign dict_needed = alloc || s1_last;

   // Id selection: keep=0 -> 0, hit -> index, miss -> next slot, full -> all-ones
   always_comb begin
      id_w = '0;
      if (!s1_keep)  id_w = '0;
      else if (hit)  id_w = IDW'(hit_idx);
      else if (!full) id_w = IDW'(count);
      else           id_w = '1;
   end

   assign out_ids.valid  = s1_valid && !ids_done;
   assign out_ids.data   = id_w;
   assign out_ids.keep   = s1_keep;
   assign out_ids.last   = s1_last;

   assign out_dict.valid = s1_valid && dict_needed && !dict_done;
   assign out_dict.data  = alloc ? s1_val : '0;
   assign out_dict.keep  = alloc;
   assign out_dict.last  = s1_last;

   assign ids_hs  = out_ids.valid && out_ids.ready;
   assign dict_hs = out_dict.valid && out_dict.ready;
   assign ids_ok  = ids_done || ids_hs;
   assign dict_ok = !dict_needed || dict_done || dict_hs;
   assign retire  = s1_valid && ids_ok && dict_ok;

   assign in.ready = !s1_valid || retire;

   // Single stage register holding the beat under lookup
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_val   <= '0;
         s1_keep  <= 1'b0;
         s1_last  <= 1'b0;
      end else if (in.valid && in.ready) begin
         s1_valid <= 1'b1;
         s1_val   <= in.data;
         s1_keep  <= in.keep;
         s1_last  <= in.last;
      end else if (retire) begin
         s1_valid <= 1'b0;
      end
   end

   // Done flags remember an early handshake so the beat is not repeated
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ids_done  <= 1'b0;
         dict_done <= 1'b0;
      end else if (retire) begin
         ids_done  <= 1'b0;
         dict_done <= 1'b0;
      end else begin
         if (ids_hs)  ids_done  <= 1'b1;
         if (dict_hs) dict_done <= 1'b1;
      end
   end

   // Valid bits and fill count; whole table drops at batch end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tbl_vld <= '0;
         count   <= '0;
      end else if (retire) begin
         if (s1_last) begin
            tbl_vld <= '0;
            count   <= '0;
         end else if (alloc) begin
            for (int i = 0; i < CAPACITY; i++)
               if (count == CW'(i)) tbl_vld[i] <= 1'b1;
            count <= count + 1'b1;
         end
      end
   end

   // Table payload is not reset; entries are qualified by tbl_vld
   always_ff @(posedge clk) begin
      if (retire && alloc)
         for (int i = 0; i < CAPACITY; i++)
            if (count == CW'(i)) tbl_val[i] <= s1_val;
   end

   // Sticky overflow, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       overflow <= 1'b0;
      else if (retire && full_miss) overflow <= 1'b1;
   end
endmodule

// File: tb/tb_dictionary_encoder.sv
// Scoreboard bench for dictionary_encoder with CAPACITY=4.
module tb_dictionary_encoder;
   typedef logic [7:0] val_t;
   typedef logic [3:0] idw_t;
   typedef struct packed {
      logic [7:0] data;
      logic       keep;
      logic       last;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ovf;

   data_i #(.T(val_t)) in_if ();
   data_i #(.T(idw_t)) ids_if ();
   data_i #(.T(val_t)) dict_if ();

   dictionary_encoder #(
      .value_t (val_t),
      .id_t    (idw_t),
      .CAPACITY(4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .in      (in_if),
      .out_ids (ids_if),
      .out_dict(dict_if),
      .overflow(ovf)
   );

   always #5 clk = ~clk;

   beat_t exp_ids[$];
   beat_t exp_dict[$];
   int mon_checks = 0, mon_errors = 0;
   int dir_checks = 0, dir_errors = 0;

   // Monitor: pop and compare on every output handshake
   always @(negedge clk) begin
      beat_t got, e;
      if (!rst) begin
         if (ids_if.valid && ids_if.ready) begin
            got = '{data: {4'b0, ids_if.data}, keep: ids_if.keep, last: ids_if.last};
            mon_checks++;
            if (exp_ids.size() == 0) begin
               mon_errors++;
               $display("FAIL ids_extra: got data=%h keep=%b last=%b, expected no beat",
                        got.data, got.keep, got.last);
            end else begin
               e = exp_ids.pop_front();
               if (got !== e) begin
                  mon_errors++;
                  $display("FAIL ids_beat: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                           got.data, got.keep, got.last, e.data, e.keep, e.last);
               end
            end
         end
         if (dict_if.valid && dict_if.ready) begin
            got = '{data: dict_if.data, keep: dict_if.keep, last: dict_if.last};
            mon_checks++;
            if (exp_dict.size() == 0) begin
               mon_errors++;
               $display("FAIL dict_extra: got data=%h keep=%b last=%b, expected no beat",
                        got.data, got.keep, got.last);
            end else begin
               e = exp_dict.pop_front();
               if (got !== e) begin
                  mon_errors++;
                  $display("FAIL dict_beat: got data=%h keep=%b last=%b, expected data=%h keep=%b last=%b",
                           got.data, got.keep, got.last, e.data, e.keep, e.last);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      dir_checks++;
      if (got !== exp) begin
         dir_errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic exp_id(input logic [7:0] d, input logic k, input logic l);
      exp_ids.push_back('{data: d, keep: k, last: l});
   endtask

   task automatic exp_dc(input logic [7:0] d, input logic k, input logic l);
      exp_dict.push_back('{data: d, keep: k, last: l});
   endtask

   // Drive one input beat; called just after a rising edge
   task automatic send(input logic [7:0] v, input logic k, input logic l);
      int n;
      in_if.data  = v;
      in_if.keep  = k;
      in_if.last  = l;
      in_if.valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_if.ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_if.ready) begin
         dir_checks++;
         dir_errors++;
         $display("FAIL send_timeout: in.ready got 0, expected 1 within 50 cycles");
      end
      @(posedge clk);
      #1;
      in_if.valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_ids.size() != 0 || exp_dict.size() != 0) && n < 60) begin
         n++;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      dir_checks++;
      if (exp_ids.size() != 0 || exp_dict.size() != 0) begin
         dir_errors++;
         $display("FAIL drain: pending ids=%0d dict=%0d, expected 0 and 0",
                  exp_ids.size(), exp_dict.size());
         exp_ids.delete();
         exp_dict.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      in_if.valid   = 1'b0;
      in_if.data    = '0;
      in_if.keep    = 1'b0;
      in_if.last    = 1'b0;
      ids_if.ready  = 1'b1;
      dict_if.ready = 1'b1;

      #22;
      chk("rst_ids_valid", {7'b0, ids_if.valid}, 8'd0);
      chk("rst_dict_valid", {7'b0, dict_if.valid}, 8'd0);
      chk("rst_in_ready", {7'b0, in_if.ready}, 8'd1);
      chk("rst_overflow", {7'b0, ovf}, 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 5,7,5,9,7(last)
      exp_id(0,1,0); exp_id(1,1,0); exp_id(0,1,0); exp_id(2,1,0); exp_id(1,1,1);
      exp_dc(5,1,0); exp_dc(7,1,0); exp_dc(9,1,0); exp_dc(0,0,1);
      send(5,1,0); send(7,1,0); send(5,1,0); send(9,1,0); send(7,1,1);
      wait_idle();

      // back-to-back duplicate 3,3,3(last)
      exp_id(0,1,0); exp_id(0,1,0); exp_id(0,1,1);
      exp_dc(3,1,0); exp_dc(0,0,1);
      send(3,1,0); send(3,1,0); send(3,1,1);
      wait_idle();
      chk("ovf_before_full", {7'b0, ovf}, 8'd0);

      // capacity 4 overflow: 1,2,3,4,5,1(last)
      exp_id(0,1,0); exp_id(1,1,0); exp_id(2,1,0); exp_id(3,1,0); exp_id(8'h0F,1,0); exp_id(0,1,1);
      exp_dc(1,1,0); exp_dc(2,1,0); exp_dc(3,1,0); exp_dc(4,1,0); exp_dc(0,0,1);
      send(1,1,0); send(2,1,0); send(3,1,0); send(4,1,0);
      chk("ovf_at_full", {7'b0, ovf}, 8'd0);
      send(5,1,0);
      send(1,1,1);
      wait_idle();
      chk("ovf_after_miss", {7'b0, ovf}, 8'd1);

      // batch reset: 8,9(last) then 9,8(last)
      exp_id(0,1,0); exp_id(1,1,1); exp_dc(8,1,0); exp_dc(9,1,1);
      exp_id(0,1,0); exp_id(1,1,1); exp_dc(9,1,0); exp_dc(8,1,1);
      send(8,1,0); send(9,1,1); send(9,1,0); send(8,1,1);
      wait_idle();
      chk("ovf_sticky", {7'b0, ovf}, 8'd1);

      // out_dict backpressure for 3 cycles on a miss
      exp_id(0,1,0); exp_id(1,1,1); exp_dc(11,1,0); exp_dc(12,1,1);
      dict_if.ready = 1'b0;
      send(11,1,0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", {7'b0, in_if.ready}, 8'd0);
         chk("stall_dict_valid", {7'b0, dict_if.valid}, 8'd1);
      end
      @(posedge clk);
      #1;
      dict_if.ready = 1'b1;
      send(12,1,1);
      wait_idle();

      // keep=0 beat between 6 and 6(last)
      exp_id(0,1,0); exp_id(0,0,0); exp_id(0,1,1);
      exp_dc(6,1,0); exp_dc(0,0,1);
      send(6,1,0); send(8'h55,0,0); send(6,1,1);
      wait_idle();

      // mid-batch reset
      exp_id(0,1,0); exp_dc(6,1,0);
      send(6,1,0);
      wait_idle();
      rst = 1'b1;
      #3;
      chk("mid_rst_ids_valid", {7'b0, ids_if.valid}, 8'd0);
      chk("mid_rst_dict_valid", {7'b0, dict_if.valid}, 8'd0);
      chk("mid_rst_in_ready", {7'b0, in_if.ready}, 8'd1);
      chk("mid_rst_overflow", {7'b0, ovf}, 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_id(0,1,1); exp_dc(6,1,1);
      send(6,1,1);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", mon_errors + dir_errors, mon_checks + dir_checks);
      $finish;
   end
endmodule
